// File: rtl/uart_rx_if.sv
// Received-byte valid/ready channel between uart_rx (master) and the command logic (slave).
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a valid/ready byte output and frame/overrun error pulses.
// Define UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rxd,
  uart_rx_if.master rx,
  output logic      frame_err,
  output logic      parity_err,
  output logic      overrun,
  output logic      busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic             r_sync1, r_sync2, r_prev;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_fin, r_stop_ok;
  logic [7:0]       r_data;
  logic             r_valid, r_frame_err, r_overrun;
  logic             w_start_edge, w_half, w_full, w_good;

  assign w_start_edge = ~r_sync2 & r_prev;
  assign w_half       = (r_cnt == HALF_M1);
  assign w_full       = (r_cnt == FULL_M1);

`ifdef UART_RX_PARITY_EN
  logic r_par_bit, r_parity_err, w_par_ok;
  assign w_par_ok = ~^{r_shift, r_par_bit};
  assign w_good   = r_fin & r_stop_ok & w_par_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_parity_err <= 1'b0;
    else        r_parity_err <= r_fin & r_stop_ok & ~w_par_ok;
  end
  assign parity_err = r_parity_err;
`else
  assign w_good     = r_fin & r_stop_ok;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_prev      <= 1'b1;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_fin       <= 1'b0;
      r_stop_ok   <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit   <= 1'b0;
`endif
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_fin   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_cnt   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_half) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= r_sync2 ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_full) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_full) begin
            r_cnt     <= '0;
            r_par_bit <= r_sync2;
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_full) begin
            r_cnt     <= '0;
            r_stop_ok <= r_sync2;
            r_fin     <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Frame outcome is acted on one cycle after the stop sample (r_fin).
      r_frame_err <= r_fin & ~r_stop_ok;
      r_overrun   <= w_good & r_valid & ~rx.rx_ready;
      if (w_good && (!r_valid || rx.rx_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx.rx_data  = r_data;
  assign rx.rx_valid = r_valid;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;
  assign busy        = (r_state != S_IDLE);

endmodule
